// File: rtl/qlearn_pkg.sv
// Shared widths and scan FSM encoding for the Q-learning
// max-Q scan datapath.
package qlearn_pkg;

    localparam int ADDR_WIDTH  = 8;
    localparam int DATA_WIDTH  = 32;
    localparam int STATE_WIDTH = 6;
    localparam int NUM_ACTIONS = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/qmax_scan_if.sv
// Request, Q-table read port and result signals of qmax_scan.
interface qmax_scan_if #(
    parameter int ADDR_WIDTH  = qlearn_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = qlearn_pkg::DATA_WIDTH,
    parameter int STATE_WIDTH = qlearn_pkg::STATE_WIDTH
);
    localparam int ACT_WIDTH = ADDR_WIDTH - STATE_WIDTH;

    logic                   i_start;
    logic [STATE_WIDTH-1:0] i_state;
    logic [ADDR_WIDTH-1:0]  o_addr_r;
    logic                   o_read_en;
    logic [DATA_WIDTH-1:0]  i_q_data;
    logic                   o_busy;
    logic                   o_done;
    logic [DATA_WIDTH-1:0]  o_max_q;
    logic [ACT_WIDTH-1:0]   o_max_action;

    modport master (
        output i_start, i_state, i_q_data,
        input  o_addr_r, o_read_en, o_busy,
        input  o_done, o_max_q, o_max_action
    );

    modport slave (
        input  i_start, i_state, i_q_data,
        output o_addr_r, o_read_en, o_busy,
        output o_done, o_max_q, o_max_action
    );
endinterface

// File: rtl/qmax_cmp.sv
// Signed running-max select: the first sample always wins,
// later ones only when strictly greater.
module qmax_cmp #(
    parameter int DATA_WIDTH = 32,
    parameter int ACT_WIDTH  = 2
) (
    input  logic [DATA_WIDTH-1:0] run_max,
    input  logic [ACT_WIDTH-1:0]  run_act,
    input  logic [DATA_WIDTH-1:0] cand,
    input  logic [ACT_WIDTH-1:0]  cand_act,
    input  logic                  first,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic [ACT_WIDTH-1:0]  act_out
);
    logic take;

    assign take    = first || ($signed(cand) > $signed(run_max));
    assign max_out = take ? cand : run_max;
    assign act_out = take ? cand_act : run_act;
endmodule

// File: rtl/qmax_scan.sv
// Scans the four actions of one state in the Q-table and
// reports the signed maximum Q-value and its action.
module qmax_scan #(
    parameter int ADDR_WIDTH  = qlearn_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = qlearn_pkg::DATA_WIDTH,
    parameter int STATE_WIDTH = qlearn_pkg::STATE_WIDTH
) (
    input logic        i_clk,
    input logic        i_rst,
    qmax_scan_if.slave bus
);
    import qlearn_pkg::*;

    localparam int AW = ADDR_WIDTH - STATE_WIDTH;
    localparam logic [AW-1:0] LAST_ACT = AW'(NUM_ACTIONS - 1);

    scan_state_t            st;
    logic [STATE_WIDTH-1:0] lat_state;
    logic [AW-1:0]          cnt;
    logic                   valid;
    logic [AW-1:0]          v_act;
    logic [DATA_WIDTH-1:0]  run_max;
    logic [AW-1:0]          run_act;
    logic [DATA_WIDTH-1:0]  nx_max;
    logic [AW-1:0]          nx_act;

    qmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACT_WIDTH  (AW)
    ) u_cmp (
        .run_max  (run_max),
        .run_act  (run_act),
        .cand     (bus.i_q_data),
        .cand_act (v_act),
        .first    (v_act == '0),
        .max_out  (nx_max),
        .act_out  (nx_act)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st               <= S_IDLE;
            lat_state        <= '0;
            cnt              <= '0;
            valid            <= 1'b0;
            v_act            <= '0;
            run_max          <= '0;
            run_act          <= '0;
            bus.o_addr_r     <= '0;
            bus.o_read_en    <= 1'b0;
            bus.o_busy       <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_max_q      <= '0;
            bus.o_max_action <= '0;
        end else begin
            // Read data lags the enable by one cycle; tag it with its action.
            valid      <= bus.o_read_en;
            v_act      <= cnt;
            bus.o_done <= 1'b0;
            if (valid) begin
                run_max <= nx_max;
                run_act <= nx_act;
            end
            unique case (st)
                S_IDLE: begin
                    if (bus.i_start) begin
                        lat_state     <= bus.i_state;
                        cnt           <= '0;
                        bus.o_addr_r  <= {bus.i_state, AW'(0)};
                        bus.o_read_en <= 1'b1;
                        bus.o_busy    <= 1'b1;
                        st            <= S_READ;
                    end
                end
                S_READ: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ACT) begin
                        bus.o_read_en <= 1'b0;
                        st            <= S_LAST;
                    end else begin
                        bus.o_addr_r <= {lat_state, cnt + 1'b1};
                    end
                end
                S_LAST: begin
                    bus.o_max_q      <= nx_max;
                    bus.o_max_action <= nx_act;
                    bus.o_done       <= 1'b1;
                    st               <= S_DONE;
                end
                S_DONE: begin
                    bus.o_busy <= 1'b0;
                    st         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qmax_scan.sv
// Directed bench for qmax_scan with a cycle-phase reference
// model and a Q-table memory responder.
module tb_qmax_scan;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    qmax_scan_if bus ();

    qmax_scan u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [31:0] mem [256];

    // Q-table responder: data appears one cycle after the read.
    always @(posedge clk) begin
        if (bus.o_read_en)
            bus.i_q_data <= mem[bus.o_addr_r];
        else
            bus.i_q_data <= $urandom;
    end

    task automatic load(input logic [5:0] s, input int a0, a1, a2, a3);
        mem[{s, 2'd0}] = a0;
        mem[{s, 2'd1}] = a1;
        mem[{s, 2'd2}] = a2;
        mem[{s, 2'd3}] = a3;
    endtask

    // Reference model: phase 1..4 read, 5 last, 6 done, 0 idle.
    int          ph;
    logic [5:0]  m_state;
    logic [7:0]  e_addr;
    logic [31:0] e_max;
    logic [1:0]  e_act;

    always @(posedge clk) begin
        if (rst) begin
            ph     = 0;
            e_addr = '0;
            e_max  = '0;
            e_act  = '0;
        end else begin
            if (ph == 0) begin
                if (bus.i_start) begin
                    ph      = 1;
                    m_state = bus.i_state;
                end
            end else if (ph == 6) begin
                ph = 0;
            end else begin
                ph++;
            end
            if (ph >= 1 && ph <= 4)
                e_addr = {m_state, 2'(ph - 1)};
            if (ph == 6) begin
                e_max = mem[{m_state, 2'd0}];
                e_act = 2'd0;
                for (int a = 1; a < 4; a++) begin
                    if ($signed(mem[{m_state, 2'(a)}]) > $signed(e_max)) begin
                        e_max = mem[{m_state, 2'(a)}];
                        e_act = 2'(a);
                    end
                end
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("read_en", 64'(bus.o_read_en), 64'(ph >= 1 && ph <= 4));
            chk("busy", 64'(bus.o_busy), 64'(ph != 0));
            chk("done", 64'(bus.o_done), 64'(ph == 6));
            chk("addr", 64'(bus.o_addr_r), 64'(e_addr));
            chk("max_q", 64'(bus.o_max_q), 64'(e_max));
            chk("max_act", 64'(bus.o_max_action), 64'(e_act));
        end
    end

    // One scan; returns cycle of done and first/last read address.
    task automatic scan(input logic [5:0] s, output int done_cyc,
                        output logic [7:0] a_first, output logic [7:0] a_last);
        bit seen = 0;
        done_cyc = -1;
        a_first  = 'x;
        a_last   = 'x;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_state = s;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_read_en) begin
                if (!seen) a_first = bus.o_addr_r;
                seen   = 1;
                a_last = bus.o_addr_r;
            end
            if (bus.o_done && done_cyc < 0) done_cyc = k;
        end
    endtask

    int         dc;
    logic [7:0] af, al;
    int         n_done;
    int         d1, d2;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_state  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_addr", 64'(bus.o_addr_r), 64'd0);
        chk("rst_max", 64'(bus.o_max_q), 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        scan(6'd0, dc, af, al);
        chk("zero_done_cyc", 64'(dc), 64'd6);
        chk("zero_addr0", 64'(af), 64'h00);
        chk("zero_addr3", 64'(al), 64'h03);
        chk("zero_max", 64'(bus.o_max_q), 64'd0);

        load(6'd5, 10, -3, 42, 7);
        scan(6'd5, dc, af, al);
        chk("s5_done_cyc", 64'(dc), 64'd6);
        chk("s5_addr0", 64'(af), 64'h14);
        chk("s5_addr3", 64'(al), 64'h17);
        chk("s5_max", 64'(bus.o_max_q), 64'd42);
        chk("s5_act", 64'(bus.o_max_action), 64'd2);

        load(6'd63, -5, -1, -9, -2);
        scan(6'd63, dc, af, al);
        chk("s63_max", 64'(bus.o_max_q), 64'hFFFF_FFFF);
        chk("s63_act", 64'(bus.o_max_action), 64'd1);

        load(6'd2, 7, 7, 3, 7);
        scan(6'd2, dc, af, al);
        chk("s2_max", 64'(bus.o_max_q), 64'd7);
        chk("s2_act", 64'(bus.o_max_action), 64'd0);

        // Abort a scan with reset in its third cycle.
        n_done = 0;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_state = 6'd5;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_done) n_done++;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                chk("abort_read_en", 64'(bus.o_read_en), 64'd0);
                chk("abort_busy", 64'(bus.o_busy), 64'd0);
                chk("abort_max", 64'(bus.o_max_q), 64'd0);
                chk("abort_act", 64'(bus.o_max_action), 64'd0);
                rst = 1'b0;
            end
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        scan(6'd5, dc, af, al);
        chk("after_abort_cyc", 64'(dc), 64'd6);
        chk("after_abort_max", 64'(bus.o_max_q), 64'd42);

        // Starts during a scan are ignored; first idle cycle accepts.
        n_done = 0;
        d1     = -1;
        d2     = -1;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_state = 6'd63;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus.i_start = (k == 2 || k == 6 || k == 7);
            bus.i_state = (k == 7) ? 6'd2 : 6'd5;
            if (bus.o_done) begin
                n_done++;
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
            if (k == 6) begin
                chk("ign_max", 64'(bus.o_max_q), 64'hFFFF_FFFF);
                chk("ign_act", 64'(bus.o_max_action), 64'd1);
            end
        end
        chk("ign_done_cnt", 64'(n_done), 64'd2);
        chk("ign_done1", 64'(d1), 64'd6);
        chk("ign_done2", 64'(d2), 64'd13);
        chk("ign_max2", 64'(bus.o_max_q), 64'd7);
        chk("ign_act2", 64'(bus.o_max_action), 64'd0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
